hazard_control_unit: RTL and testbench

Pipeline hazard sequencer for the 5-stage RISC-V core. It sits in the ID stage beside the forwarding unit. It handles the hazards forwarding cannot cover:
- load-use stalls,
- taken-branch flushes,
- data-memory wait freezes, with a timeout that halts the pipeline.

It also keeps saturating hazard counters for performance debug.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/sat_counter.sv | 19 +
 rtl/hazard_control_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM states and the
// bundled enable/flush control word it drives into the pipeline registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hcu_state_e;

    // A flushed pipeline register loads ADDI x0,x0,0 with every control field cleared.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic exmem_write;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } hcu_ctrl_t;

    localparam hcu_ctrl_t CTRL_OFF     = 7'b0000_000;
    localparam hcu_ctrl_t CTRL_DEFAULT = 7'b1111_000;
    localparam hcu_ctrl_t CTRL_FREEZE  = 7'b0000_001;
    localparam hcu_ctrl_t CTRL_BRANCH  = 7'b1111_110;
    localparam hcu_ctrl_t CTRL_LU      = 7'b0011_010;

    function automatic logic load_use_hazard(
        input logic       idex_memread,
        input logic [4:0] idex_rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2
    );
        return idex_memread && (idex_rd != 5'd0) &&
               (((idex_rd == rs1) && uses_rs1) || ((idex_rd == rs2) && uses_rs2));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// ID-stage hazard sequencer: load-use stalls, taken-branch flushes, and
// data-memory wait freezes with a timeout that halts the pipeline.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_uses_rs1,
    input  logic             IFID_uses_rs2,
    input  logic [4:0]       IDEX_rd,
    input  logic             IDEX_MemRead,
    input  logic             EX_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PC_write,
    output logic             IFID_write,
    output logic             IDEX_write,
    output logic             EXMEM_write,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             MEMWB_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mem_wait_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    hcu_state_e        state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic              mem_timeout_reg;

    logic      lu;
    logic      ms;
    logic      wait_expired;
    hcu_ctrl_t ctrl;
    logic      lu_inc;
    logic      flush_inc;
    logic      wait_inc;

    assign lu = load_use_hazard(IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_rs2,
                                IFID_uses_rs1, IFID_uses_rs2);
    assign ms = dmem_req && !dmem_ready;
    // The current waiting cycle is the TIMEOUT-th one when TIMEOUT-1 have already been counted.
    assign wait_expired = (wait_cnt_reg == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        ctrl      = CTRL_DEFAULT;
        lu_inc    = 1'b0;
        flush_inc = 1'b0;
        wait_inc  = 1'b0;
        case (state_reg)
            RUN: begin
                if (ms) begin
                    ctrl = CTRL_FREEZE;
                end else if (EX_branch_taken) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (lu) begin
                    ctrl   = CTRL_LU;
                    lu_inc = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    ctrl     = CTRL_FREEZE;
                    wait_inc = 1'b1;
                end
            end
            HALT:    ctrl = CTRL_FREEZE;
            default: ctrl = CTRL_DEFAULT;
        endcase
        // Hold the whole pipeline still while reset is asserted.
        if (!rst_n) begin
            ctrl      = CTRL_OFF;
            lu_inc    = 1'b0;
            flush_inc = 1'b0;
            wait_inc  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (ms) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_reg    <= RUN;
                        wait_cnt_reg <= '0;
                    end else if (wait_expired) begin
                        state_reg       <= HALT;
                        mem_timeout_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
                    end
                end
                HALT: state_reg <= HALT;
                default: begin
                    state_reg    <= RUN;
                    wait_cnt_reg <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_lu_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lu_inc),
        .count (lu_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .count (mem_wait_cnt)
    );

    assign PC_write    = ctrl.pc_write;
    assign IFID_write  = ctrl.ifid_write;
    assign IDEX_write  = ctrl.idex_write;
    assign EXMEM_write = ctrl.exmem_write;
    assign IFID_flush  = ctrl.ifid_flush;
    assign IDEX_flush  = ctrl.idex_flush;
    assign MEMWB_flush = ctrl.memwb_flush;
    assign state       = state_reg;
    assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (short timeout / narrow counters)
// share stimulus and are checked against a behavioural model every cycle.
module tb_hazard_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, memread, br, req, rdy;

    logic        a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf, a_to;
    logic [1:0]  a_state;
    logic [15:0] a_lu, a_fl, a_mw;
    logic        b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf, b_to;
    logic [1:0]  b_state;
    logic [1:0]  b_lu, b_fl, b_mw;
    logic [6:0]  a_ctl, b_ctl;

    assign a_ctl = {a_pcw, a_ifw, a_idw, a_exw, a_iff, a_idf, a_mwf};
    assign b_ctl = {b_pcw, b_ifw, b_idw, b_exw, b_iff, b_idf, b_mwf};

    hazard_control_unit #(.TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_uses_rs1(u1), .IFID_uses_rs2(u2),
        .IDEX_rd(rd), .IDEX_MemRead(memread), .EX_branch_taken(br),
        .dmem_req(req), .dmem_ready(rdy),
        .PC_write(a_pcw), .IFID_write(a_ifw), .IDEX_write(a_idw), .EXMEM_write(a_exw),
        .IFID_flush(a_iff), .IDEX_flush(a_idf), .MEMWB_flush(a_mwf),
        .state(a_state), .mem_timeout(a_to),
        .lu_stall_cnt(a_lu), .flush_cnt(a_fl), .mem_wait_cnt(a_mw)
    );

    hazard_control_unit #(.TIMEOUT(255), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .IFID_uses_rs1(u1), .IFID_uses_rs2(u2),
        .IDEX_rd(rd), .IDEX_MemRead(memread), .EX_branch_taken(br),
        .dmem_req(req), .dmem_ready(rdy),
        .PC_write(b_pcw), .IFID_write(b_ifw), .IDEX_write(b_idw), .EXMEM_write(b_exw),
        .IFID_flush(b_iff), .IDEX_flush(b_idf), .MEMWB_flush(b_mwf),
        .state(b_state), .mem_timeout(b_to),
        .lu_stall_cnt(b_lu), .flush_cnt(b_fl), .mem_wait_cnt(b_mw)
    );

    // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
    int m_mode[2], m_wait[2], m_lu[2], m_fl[2], m_mw[2], m_to[2];
    int tmo[2], cmax[2];
    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, mr, br, req, rdy;
        logic [6:0] ctl;
    } vec_t;
    vec_t tab[10];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sat_inc(input int x, input int mx);
        return (x < mx) ? x + 1 : mx;
    endfunction

    function automatic logic lu_now();
        logic hit;
        hit = 1'b0;
        if (memread && rd != 5'd0) begin
            if (u1 && rd == rs1) hit = 1'b1;
            if (u2 && rd == rs2) hit = 1'b1;
        end
        return hit;
    endfunction

    // Expected control word {PC,IFID,IDEX,EXMEM writes, IFID,IDEX,MEMWB flushes}.
    function automatic logic [6:0] exp_ctl(input int mode);
        if (!rst_n) return 7'b0000000;
        if (mode == 2) return 7'b0000001;
        if (mode == 1) return rdy ? 7'b1111000 : 7'b0000001;
        if (req && !rdy) return 7'b0000001;
        if (br) return 7'b1111110;
        if (lu_now()) return 7'b0011010;
        return 7'b1111000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_wait[i] = 0; m_lu[i] = 0;
            m_fl[i] = 0; m_mw[i] = 0; m_to[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (m_mode[i] == 0) begin
                if (req && !rdy) begin
                    m_mode[i] = 1;
                    m_wait[i] = 0;
                end else if (br) m_fl[i] = sat_inc(m_fl[i], cmax[i]);
                else if (lu_now()) m_lu[i] = sat_inc(m_lu[i], cmax[i]);
            end else if (m_mode[i] == 1) begin
                if (rdy) begin
                    m_mode[i] = 0;
                    m_wait[i] = 0;
                end else begin
                    m_mw[i] = sat_inc(m_mw[i], cmax[i]);
                    m_wait[i]++;
                    if (m_wait[i] >= tmo[i]) begin
                        m_mode[i] = 2;
                        m_to[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_comb(input string tag);
        chk({tag, " a.ctl"}, a_ctl, exp_ctl(m_mode[0]));
        chk({tag, " b.ctl"}, b_ctl, exp_ctl(m_mode[1]));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, " a.state"}, a_state, m_mode[0]);
        chk({tag, " a.timeout"}, a_to, m_to[0]);
        chk({tag, " a.lu_cnt"}, a_lu, m_lu[0]);
        chk({tag, " a.flush_cnt"}, a_fl, m_fl[0]);
        chk({tag, " a.wait_cnt"}, a_mw, m_mw[0]);
        chk({tag, " b.state"}, b_state, m_mode[1]);
        chk({tag, " b.timeout"}, b_to, m_to[1]);
        chk({tag, " b.lu_cnt"}, b_lu, m_lu[1]);
        chk({tag, " b.flush_cnt"}, b_fl, m_fl[1]);
        chk({tag, " b.wait_cnt"}, b_mw, m_mw[1]);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input string tag, input bit use_exp, input logic [6:0] exp);
        @(negedge clk);
        check_comb(tag);
        if (use_exp) chk({tag, " expected ctl"}, a_ctl, exp);
        @(posedge clk);
        model_step();
        #1;
        check_regs(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs({tag, " async"});
        check_comb({tag, " async"});
        chk({tag, " enables off"}, a_ctl, 7'b0000000);
        @(negedge clk);
        check_comb({tag, " held"});
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        check_regs({tag, " release"});
    endtask

    task automatic set_idle();
        rs1 = '0; rs2 = '0; rd = '0;
        u1 = 1'b0; u2 = 1'b0; memread = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    initial begin
        tmo[0] = 4;   cmax[0] = 65535;
        tmo[1] = 255; cmax[1] = 3;
        tab[0] = '{5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011010};
        tab[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111000};
        tab[2] = '{5'd7, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111000};
        tab[3] = '{5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7'b0011010};
        tab[4] = '{5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 7'b1111110};
        tab[5] = '{5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000};
        tab[6] = '{5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 7'b0000001};
        tab[7] = '{5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 7'b1111000};
        tab[8] = '{5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 7'b1111000};
        tab[9] = '{5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0011010};

        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("init");

        // Table vectors, applied back to back from RUN.
        foreach (tab[k]) begin
            rs1 = tab[k].rs1; rs2 = tab[k].rs2; rd = tab[k].rd;
            u1 = tab[k].u1; u2 = tab[k].u2; memread = tab[k].mr;
            br = tab[k].br; req = tab[k].req; rdy = tab[k].rdy;
            cycle($sformatf("vec%0d", k), 1'b1, tab[k].ctl);
            $display("vec %0d: ctl=%b state=%0d", k, a_ctl, a_state);
        end
        chk("table lu_cnt", a_lu, 3);
        chk("table flush_cnt", a_fl, 1);

        // Memory wait: three low-ready cycles, then release.
        set_idle();
        do_reset("mw");
        req = 1'b1;
        for (int c = 0; c < 3; c++) cycle($sformatf("mw freeze%0d", c), 1'b1, 7'b0000001);
        rdy = 1'b1;
        cycle("mw release", 1'b1, 7'b1111000);
        chk("mw wait_cnt", a_mw, 2);
        chk("mw state", a_state, 0);
        $display("memory wait sequence: wait_cnt=%0d", a_mw);

        // Timeout: ready held low until HALT, then ready has no effect.
        set_idle();
        do_reset("tmo");
        req = 1'b1;
        for (int c = 0; c < 5; c++) cycle($sformatf("tmo wait%0d", c), 1'b1, 7'b0000001);
        chk("tmo state", a_state, 2);
        chk("tmo flag", a_to, 1);
        rdy = 1'b1;
        for (int c = 0; c < 2; c++) cycle("halt hold", 1'b1, 7'b0000001);
        chk("halt still", a_state, 2);
        set_idle();
        do_reset("tmo clear");
        $display("timeout sequence done");

        // Saturation of the 2-bit counters.
        br = 1'b1;
        for (int c = 0; c < 5; c++) cycle("sat branch", 1'b1, 7'b1111110);
        chk("sat b.flush_cnt", b_fl, 3);
        chk("sat a.flush_cnt", a_fl, 5);
        $display("saturation sequence: b.flush_cnt=%0d", b_fl);

        // Asynchronous reset while frozen in MEM_WAIT.
        set_idle();
        do_reset("ar pre");
        req = 1'b1;
        for (int c = 0; c < 2; c++) cycle("ar wait", 1'b0, 7'b0);
        chk("ar in wait", a_state, 1);
        do_reset("ar mid-wait");
        rdy = 1'b1;
        cycle("ar after", 1'b0, 7'b0);
        $display("async reset sequence done");

        // Randomized traffic in chunks, each starting from reset.
        for (int chunk = 0; chunk < 8; chunk++) begin
            set_idle();
            do_reset($sformatf("rnd%0d reset", chunk));
            for (int c = 0; c < 60; c++) begin
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                u1 = 1'($urandom_range(0, 1));
                u2 = 1'($urandom_range(0, 1));
                memread = 1'($urandom_range(0, 1));
                br = ($urandom_range(0, 3) == 0);
                req = 1'($urandom_range(0, 1));
                rdy = ($urandom_range(0, 9) < 7);
                cycle($sformatf("rnd%0d.%0d", chunk, c), 1'b0, 7'b0);
            end
            $display("random chunk %0d: a.state=%0d lu=%0d fl=%0d mw=%0d",
                     chunk, a_state, a_lu, a_fl, a_mw);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
